// File: rtl/sgen_nco_pkg.sv
// Shared constants and helpers for the sgen_nco multi-channel NCO.
// Latency: n/a (package only).
// Backpressure: n/a.
package sgen_nco_pkg;

    localparam int PIPE_LAT = 3;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, taps on register bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam longint PI_Q30 = 64'sd3373259426;

    function automatic int ch_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // round((2^(w-1)-1) * sin(pi/2 * (k+0.5) / 2^d)) using a Q30 Taylor series
    function automatic int lut_entry(input int k, input int d, input int w);
        longint x, x2, mag, s, amp;
        x   = (PI_Q30 * longint'(2 * k + 1)) >>> (d + 2);
        x2  = (x * x) >>> 30;
        mag = x;
        s   = x;
        for (int n = 1; n <= 8; n++) begin
            mag = ((mag * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            s   = (n % 2 == 1) ? s - mag : s + mag;
        end
        amp = (longint'(1) <<< (w - 1)) - 1;
        return int'((amp * s + (longint'(1) <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/sgen_nco_qlut.sv
// Quarter-wave LUT lookup with mirrored address and quadrant sign reconstruction.
// Latency: 2 cycles from i_vld to o_valid; channel tag travels alongside.
// Backpressure: none; i_flush drops in-flight samples, outputs hold on bubbles.
module sgen_nco_qlut
    import sgen_nco_pkg::*;
#(
    parameter int gp_lut_depth = 8,
    parameter int gp_out_width = 12,
    parameter int gp_ch_width  = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_an,
    input  logic                      i_flush,
    input  logic                      i_vld,
    input  logic [gp_ch_width-1:0]    i_ch,
    input  logic [gp_lut_depth+1:0]   i_idx,
    output logic                      o_valid,
    output logic [gp_ch_width-1:0]    o_ch,
    output logic [gp_out_width-1:0]   o_sin,
    output logic [gp_out_width-1:0]   o_cos
);

    localparam int D  = gp_lut_depth;
    localparam int W  = gp_out_width;
    localparam int C  = gp_ch_width;
    localparam int LW = W - 1;

    logic [LW-1:0] lut [2**D];

    for (genvar k = 0; k < 2**D; k++) begin : g_lut
        localparam logic [LW-1:0] LV = LW'(lut_entry(k, D, W));
        assign lut[k] = LV;
    end

    logic [D-1:0]          addr;
    logic [1:0]            quad;
    logic [1:0]            q1;
    logic [LW-1:0]         l_a;
    logic [LW-1:0]         l_m;
    logic [C-1:0]          ch1;
    logic [PIPE_LAT-2:0]   vld_sr;
    logic [W-1:0]          sin_nxt;
    logic [W-1:0]          cos_nxt;
    logic [W-1:0]          pa;
    logic [W-1:0]          pm;

    assign quad = i_idx[D+1:D];
    assign addr = i_idx[D-1:0];

    // Half-LSB sampled table makes L[~a] the exact cosine partner of L[a]
    always_comb begin
        pa      = {1'b0, l_a};
        pm      = {1'b0, l_m};
        sin_nxt = pa;
        cos_nxt = pm;
        case (q1)
            2'd0: begin sin_nxt = pa;  cos_nxt = pm;  end
            2'd1: begin sin_nxt = pm;  cos_nxt = -pa; end
            2'd2: begin sin_nxt = -pa; cos_nxt = -pm; end
            default: begin sin_nxt = -pm; cos_nxt = pa; end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            vld_sr <= '0;
            q1     <= '0;
            l_a    <= '0;
            l_m    <= '0;
            ch1    <= '0;
            o_ch   <= '0;
            o_sin  <= '0;
            o_cos  <= '0;
        end else begin
            vld_sr <= i_flush ? '0 : {vld_sr[PIPE_LAT-3:0], i_vld};
            if (i_vld) begin
                q1  <= quad;
                l_a <= lut[addr];
                l_m <= lut[~addr];
                ch1 <= i_ch;
            end
            if (vld_sr[0] && !i_flush) begin
                o_ch  <= ch1;
                o_sin <= sin_nxt;
                o_cos <= cos_nxt;
            end
        end
    end

    assign o_valid = vld_sr[PIPE_LAT-2];

endmodule

// File: rtl/sgen_nco_mc.sv
// Round-robin multi-channel quadrature NCO; optional phase dither under SGEN_NCO_DITHER_EN.
// Latency: 3 cycles from the serving (stage-0) edge to o_valid.
// Backpressure: none; i_ena low inserts bubbles, i_sync restarts all channels.
module sgen_nco_mc
    import sgen_nco_pkg::*;
#(
    parameter int gp_phase_width = 24,
    parameter int gp_lut_depth   = 8,
    parameter int gp_out_width   = 12,
    parameter int gp_channels    = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_an,
    input  logic                                i_ena,
    input  logic                                i_sync,
    input  logic                                i_cfg_we,
    input  logic [ch_width(gp_channels)-1:0]    i_cfg_ch,
    input  logic [gp_phase_width-1:0]           i_cfg_fcw,
    input  logic [gp_phase_width-1:0]           i_cfg_poff,
    output logic                                o_valid,
    output logic [ch_width(gp_channels)-1:0]    o_ch,
    output logic [gp_out_width-1:0]             o_sin,
    output logic [gp_out_width-1:0]             o_cos
);

    localparam int P  = gp_phase_width;
    localparam int D  = gp_lut_depth;
    localparam int W  = gp_out_width;
    localparam int N  = gp_channels;
    localparam int C  = ch_width(N);
    localparam int IW = D + 2;

    logic [P-1:0]  acc      [N];
    logic [P-1:0]  sh_fcw   [N];
    logic [P-1:0]  sh_poff  [N];
    logic [P-1:0]  act_fcw  [N];
    logic [P-1:0]  act_poff [N];
    logic [C-1:0]  r_ch;
    logic          commit;
    logic [P-1:0]  cur_fcw;
    logic [P-1:0]  cur_poff;
    logic [P-1:0]  dith;
    logic          s0_vld;
    logic [C-1:0]  s0_ch;
    logic [IW-1:0] s0_idx;

    // Frame-start commit is visible to the channel served in the same cycle
    assign commit   = i_ena && (r_ch == '0);
    assign cur_fcw  = commit ? sh_fcw[r_ch]  : act_fcw[r_ch];
    assign cur_poff = commit ? sh_poff[r_ch] : act_poff[r_ch];

`ifdef SGEN_NCO_DITHER_EN
    localparam int DR_RAW = P - 2 - D;
    localparam int DR     = (DR_RAW > 16) ? 16 : DR_RAW;

    if (DR > 0) begin : g_dith
        logic [15:0] lfsr;
        always_ff @(posedge i_clk or negedge i_rst_an) begin
            if (!i_rst_an) begin
                lfsr <= LFSR_SEED;
            end else if (i_sync) begin
                lfsr <= LFSR_SEED;
            end else if (i_ena) begin
                lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            end
        end
        assign dith = {{(P - DR){1'b0}}, lfsr[DR-1:0]};
    end else begin : g_nodith
        assign dith = '0;
    end
`else
    assign dith = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            for (int i = 0; i < N; i++) begin
                acc[i]      <= '0;
                sh_fcw[i]   <= '0;
                sh_poff[i]  <= '0;
                act_fcw[i]  <= '0;
                act_poff[i] <= '0;
            end
            r_ch   <= '0;
            s0_vld <= 1'b0;
            s0_ch  <= '0;
            s0_idx <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_cfg_we && (i_cfg_ch == C'(i))) begin
                    sh_fcw[i]  <= i_cfg_fcw;
                    sh_poff[i] <= i_cfg_poff;
                end
            end
            if (i_sync) begin
                for (int i = 0; i < N; i++) begin
                    acc[i]      <= '0;
                    act_fcw[i]  <= sh_fcw[i];
                    act_poff[i] <= sh_poff[i];
                end
                r_ch   <= '0;
                s0_vld <= 1'b0;
            end else if (i_ena) begin
                if (commit) begin
                    for (int i = 0; i < N; i++) begin
                        act_fcw[i]  <= sh_fcw[i];
                        act_poff[i] <= sh_poff[i];
                    end
                end
                acc[r_ch] <= acc[r_ch] + cur_fcw;
                r_ch      <= (r_ch == C'(N - 1)) ? '0 : r_ch + 1'b1;
                s0_vld    <= 1'b1;
                s0_ch     <= r_ch;
                // Only quadrant + LUT address bits travel further down the pipe
                s0_idx    <= IW'((acc[r_ch] + cur_poff + dith) >> (P - IW));
            end else begin
                s0_vld <= 1'b0;
            end
        end
    end

    sgen_nco_qlut #(
        .gp_lut_depth (D),
        .gp_out_width (W),
        .gp_ch_width  (C)
    ) u_qlut (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_flush  (i_sync),
        .i_vld    (s0_vld),
        .i_ch     (s0_ch),
        .i_idx    (s0_idx),
        .o_valid  (o_valid),
        .o_ch     (o_ch),
        .o_sin    (o_sin),
        .o_cos    (o_cos)
    );

endmodule

// File: tb/tb_sgen_nco_mc.sv
// Bench for sgen_nco_mc: randomized stimulus against a frame-level NCO model using real sin/cos.
module tb_sgen_nco_mc;
    import sgen_nco_pkg::*;

    localparam int P = 24;
    localparam int D = 8;
    localparam int W = 12;
    localparam int N = 4;
    localparam int C = 2;
    localparam int unsigned MASK = 32'h00FF_FFFF;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_an = 1'b0;
    logic ena = 1'b0;
    logic sync = 1'b0;
    logic cfg_we = 1'b0;
    logic [C-1:0] cfg_ch = '0;
    logic [P-1:0] cfg_fcw = '0;
    logic [P-1:0] cfg_poff = '0;
    logic o_valid;
    logic [C-1:0] o_ch;
    logic signed [W-1:0] o_sin;
    logic signed [W-1:0] o_cos;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int unsigned m_acc[N], m_sfcw[N], m_spoff[N], m_afcw[N], m_apoff[N];
    int m_ch;
    bit p_vld[3];
    int p_ch[3], p_sin[3], p_cos[3];
    logic e_vld;
    logic [C-1:0] e_ch;
    logic signed [W-1:0] e_sin, e_cos;

    sgen_nco_mc dut (
        .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_sync(sync),
        .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch), .i_cfg_fcw(cfg_fcw), .i_cfg_poff(cfg_poff),
        .o_valid(o_valid), .o_ch(o_ch), .o_sin(o_sin), .o_cos(o_cos)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    task automatic ref_sample(input int unsigned ph, output int s, output int c);
        real ang, amp;
        ang = 2.0 * PI * (real'(ph >> (P - 2 - D)) + 0.5) / real'(1 << (D + 2));
        amp = real'((1 << (W - 1)) - 1);
        s = rnd(amp * $sin(ang));
        c = rnd(amp * $cos(ang));
    endtask

    function automatic string obs();
        return $sformatf("got v=%b ch=%0d sin=%0d cos=%0d want v=%b ch=%0d sin=%0d cos=%0d",
                         o_valid, o_ch, o_sin, o_cos, e_vld, e_ch, e_sin, e_cos);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0; m_sfcw[i] = 0; m_spoff[i] = 0; m_afcw[i] = 0; m_apoff[i] = 0;
        end
        m_ch = 0;
        for (int k = 0; k < 3; k++) p_vld[k] = 1'b0;
        e_vld = 1'b0; e_ch = '0; e_sin = '0; e_cos = '0;
    endtask

    // advance model by one clock using current inputs, then one DUT edge
    task automatic tick();
        bit nv;
        int nch, ns, nc;
        int unsigned ph;
        nv = 1'b0; nch = 0; ns = 0; nc = 0;
        if (sync) begin
            for (int i = 0; i < N; i++) begin
                m_acc[i] = 0; m_afcw[i] = m_sfcw[i]; m_apoff[i] = m_spoff[i];
            end
            m_ch = 0;
        end else if (ena) begin
            if (m_ch == 0)
                for (int i = 0; i < N; i++) begin
                    m_afcw[i] = m_sfcw[i]; m_apoff[i] = m_spoff[i];
                end
            ph = (m_acc[m_ch] + m_apoff[m_ch]) & MASK;
            ref_sample(ph, ns, nc);
            nv = 1'b1; nch = m_ch;
            m_acc[m_ch] = (m_acc[m_ch] + m_afcw[m_ch]) & MASK;
            m_ch = (m_ch + 1) % N;
        end
        if (cfg_we && int'(cfg_ch) < N) begin
            m_sfcw[cfg_ch] = cfg_fcw;
            m_spoff[cfg_ch] = cfg_poff;
        end
        for (int k = 2; k > 0; k--) begin
            p_vld[k] = p_vld[k-1]; p_ch[k] = p_ch[k-1]; p_sin[k] = p_sin[k-1]; p_cos[k] = p_cos[k-1];
        end
        p_vld[0] = nv; p_ch[0] = nch; p_sin[0] = ns; p_cos[0] = nc;
        if (sync) for (int k = 0; k < 3; k++) p_vld[k] = 1'b0;
        @(posedge clk); #1;
        if (p_vld[2]) begin
            e_vld = 1'b1; e_ch = C'(p_ch[2]); e_sin = W'(p_sin[2]); e_cos = W'(p_cos[2]);
        end else begin
            e_vld = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_an = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (o_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %b want 0", o_valid);
        end
        n_chk++;
        if ({o_ch, o_sin, o_cos} !== '0) begin
            n_err++; $display("FAIL reset_data got ch=%0d sin=%0d cos=%0d want 0/0/0", o_ch, o_sin, o_cos);
        end
        rst_an = 1'b1;
    endtask

    task automatic test_defaults();
        int first;
        first = -1;
        ena = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            tick();
            n_chk++;
            if ({o_valid, o_ch, o_sin, o_cos} !== {e_vld, e_ch, e_sin, e_cos}) begin
                n_err++; $display("FAIL defaults t=%0d %s", t, obs());
            end
            if (o_valid === 1'b1 && first < 0) first = t;
        end
        n_chk++;
        if (first != PIPE_LAT) begin
            n_err++; $display("FAIL latency got %0d want %0d", first, PIPE_LAT);
        end
        n_chk++;
        if (o_sin !== 12'sd6 || o_cos !== 12'sd2047) begin
            n_err++; $display("FAIL zero_phase got sin=%0d cos=%0d want 6/2047", o_sin, o_cos);
        end
    endtask

    task automatic test_quadrants();
        int qs[3], qc[3];
        logic [P-1:0] offs[3];
        qs = '{2047, -6, -2047};
        qc = '{-6, -2047, 6};
        offs = '{24'h400000, 24'h800000, 24'hC00000};
        ena = 1'b1;
        for (int t = 0; t < 18; t++) begin
            cfg_we = (t < 3);
            cfg_ch = C'(t);
            cfg_fcw = '0;
            cfg_poff = offs[t < 3 ? t : 0];
            tick();
            n_chk++;
            if ({o_valid, o_ch, o_sin, o_cos} !== {e_vld, e_ch, e_sin, e_cos}) begin
                n_err++; $display("FAIL quadrants t=%0d %s", t, obs());
            end
            if (t >= 10 && o_valid === 1'b1 && o_ch < 3) begin
                n_chk++;
                if (o_sin !== W'(qs[o_ch]) || o_cos !== W'(qc[o_ch])) begin
                    n_err++;
                    $display("FAIL quad_const ch=%0d got sin=%0d cos=%0d want %0d/%0d",
                             o_ch, o_sin, o_cos, qs[o_ch], qc[o_ch]);
                end
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_fcw_wrap();
        int f;
        logic signed [W-1:0] s0, c0;
        f = 0; s0 = '0; c0 = '0;
        sync = 1'b1; cfg_we = 1'b1; cfg_ch = '0; cfg_fcw = 24'h010000; cfg_poff = 24'h400000;
        tick();
        sync = 1'b0; cfg_we = 1'b0;
        for (int t = 0; t < 1040; t++) begin
            tick();
            n_chk++;
            if ({o_valid, o_ch, o_sin, o_cos} !== {e_vld, e_ch, e_sin, e_cos}) begin
                n_err++; $display("FAIL fcw_wrap t=%0d %s", t, obs());
            end
            if (o_valid === 1'b1 && o_ch === '0) begin
                if (f == 0) begin
                    s0 = o_sin; c0 = o_cos;
                end else if (f == 128) begin
                    n_chk++;
                    if (o_sin !== -s0 || o_cos !== -c0) begin
                        n_err++; $display("FAIL half_turn got %0d/%0d want %0d/%0d", o_sin, o_cos, -s0, -c0);
                    end
                end else if (f == 256) begin
                    n_chk++;
                    if (o_sin !== s0 || o_cos !== c0) begin
                        n_err++; $display("FAIL wrap got %0d/%0d want %0d/%0d", o_sin, o_cos, s0, c0);
                    end
                end
                f++;
            end
        end
        n_chk++;
        if (f < 257) begin
            n_err++; $display("FAIL wrap_frames got %0d want >=257", f);
        end
    endtask

    task automatic test_cfg_timing();
        int targets[2];
        targets = '{0, 2};
        ena = 1'b1;
        foreach (targets[j]) begin
            for (int g = 0; g < 8 && m_ch != targets[j]; g++) begin
                tick();
                n_chk++;
                if ({o_valid, o_ch, o_sin, o_cos} !== {e_vld, e_ch, e_sin, e_cos}) begin
                    n_err++; $display("FAIL cfg_align %s", obs());
                end
            end
            cfg_we = 1'b1; cfg_ch = 2'd1; cfg_fcw = P'($urandom); cfg_poff = P'($urandom);
            for (int t = 0; t < 14; t++) begin
                tick();
                cfg_we = 1'b0;
                n_chk++;
                if ({o_valid, o_ch, o_sin, o_cos} !== {e_vld, e_ch, e_sin, e_cos}) begin
                    n_err++; $display("FAIL cfg_timing tgt=%0d t=%0d %s", targets[j], t, obs());
                end
            end
        end
    endtask

    task automatic test_ena_toggle();
        for (int t = 0; t < 80; t++) begin
            ena = (t < 40) ? (t % 2 == 0) : ($urandom_range(0, 1) == 1);
            tick();
            n_chk++;
            if ({o_valid, o_ch, o_sin, o_cos} !== {e_vld, e_ch, e_sin, e_cos}) begin
                n_err++; $display("FAIL ena_toggle t=%0d %s", t, obs());
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_sync();
        int unsigned poff0;
        int s, c;
        ena = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            n_chk++;
            if ({o_valid, o_ch, o_sin, o_cos} !== {e_vld, e_ch, e_sin, e_cos}) begin
                n_err++; $display("FAIL sync_pre t=%0d %s", t, obs());
            end
        end
        poff0 = m_spoff[0];
        ref_sample(poff0 & MASK, s, c);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) tick();
            n_chk++;
            if (k < 3 && o_valid !== 1'b0) begin
                n_err++; $display("FAIL sync_gap k=%0d got v=%b want 0", k, o_valid);
            end else if (k == 3 && (o_valid !== 1'b1 || o_ch !== '0 || o_sin !== W'(s) || o_cos !== W'(c))) begin
                n_err++; $display("FAIL sync_first got v=%b ch=%0d %0d/%0d want 1/0 %0d/%0d",
                                  o_valid, o_ch, o_sin, o_cos, s, c);
            end
        end
    endtask

    task automatic test_reset_mid();
        ena = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        #3 rst_an = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if ({o_valid, o_ch, o_sin, o_cos} !== '0) begin
            n_err++; $display("FAIL reset_mid %s", obs());
        end
        @(posedge clk); #1;
        rst_an = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            n_chk++;
            if ({o_valid, o_ch, o_sin, o_cos} !== {e_vld, e_ch, e_sin, e_cos}) begin
                n_err++; $display("FAIL reset_resume t=%0d %s", t, obs());
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            ena = ($urandom_range(0, 3) != 0);
            sync = ($urandom_range(0, 49) == 0);
            cfg_we = ($urandom_range(0, 4) == 0);
            cfg_ch = C'($urandom);
            cfg_fcw = P'($urandom);
            cfg_poff = P'($urandom);
            tick();
            n_chk++;
            if ({o_valid, o_ch, o_sin, o_cos} !== {e_vld, e_ch, e_sin, e_cos}) begin
                n_err++; $display("FAIL random t=%0d %s", t, obs());
            end
        end
        ena = 1'b0; sync = 1'b0; cfg_we = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_defaults();
        test_quadrants();
        test_fcw_wrap();
        test_cfg_timing();
        test_ena_toggle();
        test_sync();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
